// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV64 instruction encoder: opcodes, the NOP word, FSM states and the field bundle.
// IMM_RANGE_CHECK_EN (when defined) enables immediate range flagging.
package instr_encoder_pkg;

    localparam logic [6:0]  OP_R     = 7'b0110011;
    localparam logic [6:0]  OP_I     = 7'b0010011;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_S     = 7'b0100011;
    localparam logic [6:0]  OP_B     = 7'b1100011;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [63:0] imm;
    } fields_t;

    // True when v is the sign extension of its low msb+1 bits.
    function automatic logic imm_fits(input logic [63:0] v, input int unsigned msb);
        logic [63:0] upper;
        upper = $signed(v) >>> msb;
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-beat input stream and encoded-word output stream of the instruction encoder.
// master = field producer / word consumer, slave = encoder.
interface instr_encoder_if #(
    parameter int ADDR_W   = 32,
    parameter int ERRCNT_W = 8
);
    logic                start;
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [63:0]         imm;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_instr;
    logic [ADDR_W-1:0]   out_addr;
    logic                out_last;
    logic                out_err;
    logic [ERRCNT_W-1:0] err_count;
    logic                done;

    modport master (
        output start, in_valid, in_last, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_last, out_err, err_count, done
    );

    modport slave (
        input  start, in_valid, in_last, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_last, out_err, err_count, done
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer: decoded fields + immediate -> 32-bit R/I/S/B instruction word and error flag.
// Immediate range flagging is active only when IMM_RANGE_CHECK_EN is defined.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  fields_t     fields,
    output logic [31:0] word,
    output logic        err
);

    logic bad_op;
    logic range_bad;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        word      = NOP_WORD;
        bad_op    = 1'b0;
        range_bad = 1'b0;
        case (fields.opcode)
            OP_R: begin
                word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
            end
            OP_I, OP_LOAD: begin
                word      = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
                range_bad = !imm_fits(fields.imm, 11);
            end
            OP_S: begin
                word      = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                             fields.imm[4:0], fields.opcode};
                range_bad = !imm_fits(fields.imm, 11);
            end
            OP_B: begin
                word      = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                             fields.imm[4:1], fields.imm[11], fields.opcode};
                range_bad = !imm_fits(fields.imm, 12) || fields.imm[0];
            end
            default: bad_op = 1'b1;
        endcase
    end

    // Out-of-range immediates are still packed from their truncated bits; only the flag differs.
    assign err = bad_op || (RANGE_CHECK && range_bad);

endmodule

// File: rtl/instr_encoder.sv
// Streams packed RV64 instruction words with byte addresses to the instruction-memory loader, framed by start/last.
// Define IMM_RANGE_CHECK_EN to also flag out-of-range immediates.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERRCNT_W  = 8
) (
    input logic           clk,
    input logic           reset,
    instr_encoder_if.slave bus
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] next_addr;
    fields_t           fields;
    logic [31:0]       packed_word;
    logic              packed_err;
    logic              accept;
    logic              out_fire;

    assign fields = '{opcode: bus.opcode, rd: bus.rd, rs1: bus.rs1, rs2: bus.rs2,
                      funct3: bus.funct3, funct7: bus.funct7, imm: bus.imm};

    instr_pack u_pack (
        .fields (fields),
        .word   (packed_word),
        .err    (packed_err)
    );

    assign bus.in_ready = (state == ST_RUN) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_fire     = bus.out_valid && bus.out_ready;
    assign bus.done     = (state == ST_DRAIN) && out_fire && bus.out_last;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (bus.start)                state_next = ST_RUN;
            ST_RUN:   if (accept && bus.in_last)    state_next = ST_DRAIN;
            ST_DRAIN: if (out_fire && bus.out_last) state_next = ST_IDLE;
            default:                                state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_addr  <= BASE_ADDR;
            bus.out_last  <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.err_count <= '0;
            next_addr     <= BASE_ADDR;
        end else begin
            if (state == ST_IDLE && bus.start) begin
                bus.err_count <= '0;
                next_addr     <= BASE_ADDR;
            end
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_instr <= packed_word;
                bus.out_err   <= packed_err;
                bus.out_last  <= bus.in_last;
                bus.out_addr  <= next_addr;
                next_addr     <= next_addr + ADDR_W'(4);
                if (packed_err && (bus.err_count != '1))
                    bus.err_count <= bus.err_count + 1'b1;
            end else if (out_fire) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed load sequences, a cycle-level reference model
// compared every cycle, and literal expectations for the documented encodings.
module tb_instr_encoder;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] BASE     = 32'h0000_0000;
    localparam int          ERRCNT_W = 8;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .ERRCNT_W(ERRCNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the format tables, using arithmetic on field values.
    function automatic void model_encode(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [63:0] imm, output logic [31:0] w, output bit e);
        longint          s;
        longint unsigned u;
        longint unsigned acc;
        s   = imm;
        u   = imm;
        e   = 0;
        acc = 0;
        case (op)
            7'h33: acc = f7 * (64'd1 << 25) + rs2 * (64'd1 << 20) + rs1 * (64'd1 << 15)
                       + f3 * (64'd1 << 12) + rd * (64'd1 << 7) + op;
            7'h13, 7'h03: begin
                acc = (u % 4096) * (64'd1 << 20) + rs1 * (64'd1 << 15) + f3 * (64'd1 << 12)
                    + rd * (64'd1 << 7) + op;
                e = RC && (s < -2048 || s > 2047);
            end
            7'h23: begin
                acc = ((u / 32) % 128) * (64'd1 << 25) + rs2 * (64'd1 << 20) + rs1 * (64'd1 << 15)
                    + f3 * (64'd1 << 12) + (u % 32) * (64'd1 << 7) + op;
                e = RC && (s < -2048 || s > 2047);
            end
            7'h63: begin
                acc = ((u / 4096) % 2) * (64'd1 << 31) + ((u / 32) % 64) * (64'd1 << 25)
                    + rs2 * (64'd1 << 20) + rs1 * (64'd1 << 15) + f3 * (64'd1 << 12)
                    + ((u / 2) % 16) * (64'd1 << 8) + ((u / 2048) % 2) * (64'd1 << 7) + op;
                e = RC && (s < -4096 || s > 4095 || (u % 2) == 1);
            end
            default: begin
                acc = 64'h13;
                e   = 1;
            end
        endcase
        w = acc[31:0];
    endfunction

    // Cycle-level reference: phase 0 idle, 1 loading, 2 waiting for the last word to leave.
    int          m_phase;
    bit          m_valid, m_last, m_err, m_acc, m_fire, m_e;
    logic [31:0] m_word, m_addr, m_next, m_w;
    int          m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_valid = 0; m_word = 0; m_addr = BASE; m_next = BASE;
            m_last = 0;  m_err = 0;   m_cnt = 0;
        end else begin
            m_fire = m_valid && bus.out_ready;
            m_acc  = (m_phase == 1) && bus.in_valid && (!m_valid || bus.out_ready);
            if (m_phase == 2 && m_fire && m_last) m_phase = 0;
            else if (m_phase == 0 && bus.start) begin
                m_phase = 1; m_cnt = 0; m_next = BASE;
            end
            if (m_fire) m_valid = 0;
            if (m_acc) begin
                model_encode(bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.funct7, bus.imm, m_w, m_e);
                m_valid = 1; m_word = m_w; m_err = m_e; m_last = bus.in_last;
                m_addr = m_next; m_next = m_next + 4;
                if (m_e && m_cnt < 255) m_cnt++;
                if (bus.in_last) m_phase = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", bus.in_ready, (m_phase == 1) && (!m_valid || bus.out_ready));
            check("out_valid", bus.out_valid, m_valid);
            check("err_count", bus.err_count, m_cnt);
            check("done", bus.done, (m_phase == 2) && m_valid && bus.out_ready && m_last);
            if (m_valid) begin
                check("out_instr", bus.out_instr, m_word);
                check("out_addr", bus.out_addr, m_addr);
                check("out_last", bus.out_last, m_last);
                check("out_err", bus.out_err, m_err);
            end
        end
    end

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [63:0] imm, input logic last);
        bus.opcode = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
        bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm; bus.in_last = last;
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] imm, input logic last);
        bit got;
        got = 0;
        set_fields(op, rd, rs1, rs2, f3, f7, imm, last);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1;
            @(posedge clk); #1;
        end
        if (!got) check("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
            @(posedge clk); #1;
        end
        check("done_seen", seen, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_instr"}, bus.out_instr, 0);
        check({tag, "_out_addr"}, bus.out_addr, BASE);
        check({tag, "_out_last"}, bus.out_last, 0);
        check({tag, "_out_err"}, bus.out_err, 0);
        check({tag, "_err_count"}, bus.err_count, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_in_ready"}, bus.in_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 0; bus.in_valid = 0; bus.out_ready = 1;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1 check_reset_values("reset");
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;

        // 1: ADDI x1,x2,12
        do_start();
        send(7'h13, 1, 2, 0, 0, 0, 64'd12, 1);
        check("t1_instr", bus.out_instr, 32'h00C10093);
        check("t1_addr", bus.out_addr, 0);
        check("t1_err", bus.out_err, 0);
        wait_done();

        // 2: SW x1,20(x2) then BEQ x1,x2,-16 back-to-back
        do_start();
        send(7'h23, 0, 2, 1, 3'd2, 0, 64'd20, 0);
        check("t2_sw_instr", bus.out_instr, 32'h00112A23);
        check("t2_sw_addr", bus.out_addr, 0);
        check("t2_sw_last", bus.out_last, 0);
        send(7'h63, 0, 1, 2, 3'd0, 0, -64'sd16, 1);
        check("t2_beq_instr", bus.out_instr, 32'hFE2088E3);
        check("t2_beq_addr", bus.out_addr, 4);
        check("t2_beq_last", bus.out_last, 1);
        wait_done();

        // 3: SUB, LD, then an unknown opcode
        do_start();
        send(7'h33, 3, 1, 2, 0, 7'h20, 0, 0);
        check("t3_sub_instr", bus.out_instr, 32'h402081B3);
        send(7'h03, 5, 6, 0, 3'd3, 0, -64'sd8, 0);
        check("t3_ld_instr", bus.out_instr, 32'hFF833283);
        send(7'h7F, 1, 2, 3, 0, 0, 0, 1);
        check("t3_bad_instr", bus.out_instr, 32'h00000013);
        check("t3_bad_err", bus.out_err, 1);
        check("t3_err_count", bus.err_count, 1);
        wait_done();

        // 4: ADDI with an immediate just out of 12-bit range
        do_start();
        send(7'h13, 1, 2, 0, 0, 0, 64'd2048, 1);
        check("t4_instr", bus.out_instr, 32'h80010093);
        check("t4_err", bus.out_err, RC);
        wait_done();

        // 5: consumer stall with a second beat waiting
        do_start();
        bus.out_ready = 1'b0;
        send(7'h13, 3, 0, 0, 0, 0, 64'd5, 0);
        set_fields(7'h13, 4, 0, 0, 0, 0, 64'd7, 1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_stall_in_ready", bus.in_ready, 0);
            check("t5_stall_instr", bus.out_instr, 32'h00500193);
            check("t5_stall_addr", bus.out_addr, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t5_release_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("t5_next_instr", bus.out_instr, 32'h00700213);
        check("t5_next_addr", bus.out_addr, 4);
        wait_done();

        // 6: reset in the middle of a load, then a fresh load
        do_start();
        send(7'h13, 1, 1, 0, 0, 0, 64'd1, 0);
        send(7'h13, 2, 2, 0, 0, 0, 64'd2, 0);
        #3 reset = 1'b1;
        #1 check_reset_values("midreset");
        @(posedge clk); #1 reset = 1'b0;
        do_start();
        send(7'h13, 1, 2, 0, 0, 0, 64'd12, 1);
        check("t6_restart_addr", bus.out_addr, BASE);
        check("t6_restart_instr", bus.out_instr, 32'h00C10093);
        wait_done();

        // 7: err_count saturation, then cleared by the next start
        do_start();
        for (int i = 0; i < 257; i++) send(7'h7F, 0, 0, 0, 0, 0, 0, (i == 256));
        check("t7_err_sat", bus.err_count, 8'hFF);
        wait_done();
        do_start();
        check("t7_err_cleared", bus.err_count, 0);
        send(7'h13, 0, 0, 0, 0, 0, 0, 1);
        check("t7_nop_instr", bus.out_instr, 32'h00000013);
        wait_done();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
